// File: rtl/dsp_ce_sequencer.sv
// Per-job clock-enable / clear / accumulate-select sequencer for a DSP48A1-style MAC pipeline.
// Each accepted operand launches a tag that fires every stage enable as its data reaches that stage.
module dsp_ce_sequencer #(
   parameter int CNT_W  = 8,
   parameter int INREG  = 1,
   parameter int MIDREG = 1,
   parameter int MREG   = 1,
   parameter int PREG   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [CNT_W-1:0] start_len,
   input  logic             op_valid,
   output logic             op_ready,
   output logic             ce_in,
   output logic             ce_mid,
   output logic             ce_m,
   output logic             ce_p,
   output logic             rst_p,
   output logic             opmode_acc,
   output logic             busy,
   output logic             done
);

   localparam int D = INREG + MIDREG + MREG;
   localparam int L = D + PREG;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_CLEAR = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             first_q, first_d;
   logic [2:0]       tag_v_q, tag_v_d;
   logic [2:0]       tag_f_q, tag_f_d;

   logic             accept_s;
   logic [3:0]       stg_v_s;
   logic [3:0]       stg_f_s;
   logic             chain_busy_s;
   logic             acc_sel_s;

   assign start_ready = (state_q == S_IDLE);
   assign op_ready    = (state_q == S_RUN);
   assign busy        = (state_q != S_IDLE);
   assign rst_p       = (state_q == S_CLEAR);
   assign done        = (state_q == S_DONE);

   // Stage 0 of the tag chain is the handshake itself; stages 1..3 are flops.
   assign accept_s = op_valid & op_ready;
   assign stg_v_s  = {tag_v_q, accept_s};
   assign stg_f_s  = {tag_f_q, first_q};

   assign ce_in      = accept_s;
   assign ce_mid     = stg_v_s[INREG];
   assign ce_m       = stg_v_s[INREG + MIDREG];
   assign ce_p       = stg_v_s[D];
   assign opmode_acc = acc_sel_s;

   // Accumulate select rides with the P-stage tag: load on the job's first operand, accumulate after.
   always_comb begin
      acc_sel_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == D) begin
            acc_sel_s = stg_v_s[i] & ~stg_f_s[i];
         end else begin
            acc_sel_s = acc_sel_s;
         end
      end
   end

   // Tags still short of the final stage keep DRAIN waiting; the last one completes in the DONE transition.
   always_comb begin
      chain_busy_s = 1'b0;
      for (int i = 1; i < 4; i++) begin
         chain_busy_s = chain_busy_s | (stg_v_s[i] & (i < L));
      end
   end

   // Next-state, operand counter and tag-chain shift.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      first_d = first_q;
      tag_v_d = stg_v_s[2:0];
      tag_f_d = stg_f_s[2:0];
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               if (start_len == {CNT_W{1'b0}}) begin
                  state_d = S_CLEAR;
               end else begin
                  rem_d   = start_len;
                  first_d = 1'b1;
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept_s) begin
               rem_d   = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
               first_d = 1'b0;
               if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  if (L == 0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (!chain_busy_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_CLEAR: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and tag registers; reset empties the chain so no enable can survive an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= {CNT_W{1'b0}};
         first_q <= 1'b0;
         tag_v_q <= 3'b000;
         tag_f_q <= 3'b000;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         first_q <= first_d;
         tag_v_q <= tag_v_d;
         tag_f_q <= tag_f_d;
      end
   end

endmodule

// File: tb/tb_dsp_ce_sequencer.sv
// Bench for dsp_ce_sequencer: a fully registered and a fully bypassed instance share stimulus,
// each checked every cycle against an event-schedule reference model.
module tb_dsp_ce_sequencer;

   localparam int NC = 8192;
   localparam logic [9:0] RST_VEC = 10'b1000000000;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_valid;
   logic [7:0] start_len;
   logic       op_valid;
   logic [1:0] start_ready, op_ready, ce_in, ce_mid, ce_m, ce_p;
   logic [1:0] rst_p, opmode_acc, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state per instance (0: all stages registered, 1: all bypassed)
   int in_r[2]  = '{1, 0};
   int mid_r[2] = '{1, 0};
   int m_r[2]   = '{1, 0};
   int p_r[2]   = '{1, 0};
   bit act[2];
   bit first[2];
   int rem[2];
   int done_at[2];
   int clr_at[2];
   bit s_mid[2][NC];
   bit s_m[2][NC];
   bit s_p[2][NC];
   bit s_acc[2][NC];

   always #5 clk = ~clk;

   dsp_ce_sequencer #(.CNT_W(8), .INREG(1), .MIDREG(1), .MREG(1), .PREG(1)) u_reg (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready[0]),
      .start_len(start_len), .op_valid(op_valid), .op_ready(op_ready[0]),
      .ce_in(ce_in[0]), .ce_mid(ce_mid[0]), .ce_m(ce_m[0]), .ce_p(ce_p[0]),
      .rst_p(rst_p[0]), .opmode_acc(opmode_acc[0]), .busy(busy[0]), .done(done[0])
   );

   dsp_ce_sequencer #(.CNT_W(8), .INREG(0), .MIDREG(0), .MREG(0), .PREG(0)) u_byp (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready[1]),
      .start_len(start_len), .op_valid(op_valid), .op_ready(op_ready[1]),
      .ce_in(ce_in[1]), .ce_mid(ce_mid[1]), .ce_m(ce_m[1]), .ce_p(ce_p[1]),
      .rst_p(rst_p[1]), .opmode_acc(opmode_acc[1]), .busy(busy[1]), .done(done[1])
   );

   function automatic logic [9:0] observed(int k);
      return {start_ready[k], op_ready[k], ce_in[k], ce_mid[k], ce_m[k], ce_p[k],
              rst_p[k], opmode_acc[k], busy[k], done[k]};
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         act[k] = 1'b0; first[k] = 1'b0; rem[k] = 0; done_at[k] = -1; clr_at[k] = -1;
         for (int c = 0; c < NC; c++) begin
            s_mid[k][c] = 1'b0; s_m[k][c] = 1'b0; s_p[k][c] = 1'b0; s_acc[k][c] = 1'b0;
         end
      end
   endtask

   // Job-level rules: operands flow while a job has some left; each accepted operand
   // schedules its stage enables at fixed offsets; done follows the last P enable.
   task automatic model_check(int k);
      logic [9:0] exp_v;
      logic [9:0] obs_v;
      bit rdy, acc, act_old;
      int dp;
      act_old = act[k];
      rdy = act[k] && (rem[k] > 0);
      acc = rdy && op_valid;
      dp  = cyc + in_r[k] + mid_r[k] + m_r[k];
      if (acc) begin
         s_mid[k][cyc + in_r[k]] = 1'b1;
         s_m[k][cyc + in_r[k] + mid_r[k]] = 1'b1;
         s_p[k][dp] = 1'b1;
         s_acc[k][dp] = !first[k];
      end
      exp_v = {!act[k], rdy, acc, s_mid[k][cyc], s_m[k][cyc], s_p[k][cyc],
               (cyc == clr_at[k]), s_p[k][cyc] & s_acc[k][cyc], act[k], (cyc == done_at[k])};
      obs_v = observed(k);
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL outputs dut%0d cyc=%0d observed=%b expected=%b", k, cyc, obs_v, exp_v);
      end
      if (acc) begin
         first[k] = 1'b0;
         rem[k]   = rem[k] - 1;
         if (rem[k] == 0) done_at[k] = dp + p_r[k] + 1;
      end
      if (act_old && (cyc == done_at[k])) act[k] = 1'b0;
      if (!act_old && start_valid) begin
         act[k]   = 1'b1;
         first[k] = 1'b1;
         rem[k]   = int'(start_len);
         if (start_len == 8'd0) begin
            clr_at[k]  = cyc + 1;
            done_at[k] = cyc + 2;
         end
      end
   endtask

   task automatic step(bit sv, int len, bit ov);
      start_valid = sv;
      start_len   = 8'(len);
      op_valid    = ov;
      @(negedge clk);
      model_check(0);
      model_check(1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         assert (observed(k) === RST_VEC) else begin
            errors++;
            $error("FAIL reset dut%0d observed=%b expected=%b", k, observed(k), RST_VEC);
         end
      end
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
   endtask

   initial begin
      rst = 1'b1; start_valid = 1'b0; start_len = 8'd0; op_valid = 1'b1;
      do_reset();
      step(0, 0, 0);

      // len=3, operands back to back
      step(1, 3, 0);
      repeat (3) step(0, 0, 1);
      repeat (8) step(0, 0, 0);

      // len=2 with a two-cycle bubble
      step(1, 2, 0);
      step(0, 0, 1); step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
      repeat (8) step(0, 0, 0);

      // len=0 clears P only
      step(1, 0, 1);
      repeat (4) step(0, 0, 1);

      // abort a len=5 job after two accepts, then a clean len=1 job
      step(1, 5, 0);
      step(0, 0, 1); step(0, 0, 1);
      op_valid = 1'b1;
      do_reset();
      step(1, 1, 0);
      step(0, 0, 1);
      repeat (8) step(0, 0, 0);

      // start request held high throughout
      for (int i = 0; i < 40; i++) step(1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat (10) step(0, 0, 0);

      // random traffic with occasional aborts
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            op_valid = 1'($urandom_range(0, 1));
            do_reset();
         end else begin
            step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), ($urandom_range(0, 2) != 0));
         end
      end
      repeat (40) step(0, 0, 0);

      // maximum-length job
      step(1, 255, 0);
      for (int i = 0; i < 420; i++) step(0, 0, ($urandom_range(0, 7) != 0));
      repeat (10) step(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsp_ce_sequencer.md
# dsp_ce_sequencer

Control sequencer that drives the clock-enable, accumulator-clear and accumulate-select lines of the DSP48A1 datapath pipeline registers for one multiply-accumulate job. It accepts a job length, then accepts that many operand pairs over a valid/ready stream. It asserts each pipeline stage's enable exactly when that operand's data reaches the stage, and pulses `done` once the final sum is held in the P register. It sits between the host/stream logic and the slice's per-stage enable/reset pins, so it is the source end of the enable/reset interface those registers consume.

## Interface
- `CNT_W`, 8: width of job length and operand counter; max job length 2^CNT_W-1.
- `INREG`, 1: input stage (A0/B0/D/C) registered (1) or bypassed (0).
- `MIDREG`, 1: pre-adder output stage (A1/B1) registered (1) or bypassed (0).
- `MREG`, 1: multiplier output stage registered (1) or bypassed (0).
- `PREG`, 1: post-adder/accumulator P stage registered (1) or bypassed (0).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  job request.
- `start_ready`  out  1  high only in IDLE.
- `start_len`  in  CNT_W  operand pairs in job; sampled on start handshake.
- `op_valid`  in  1  operand pair present on datapath inputs this cycle.
- `op_ready`  out  1  high in RUN while operands remain.
- `ce_in`  out  1  enable for input-stage registers.
- `ce_mid`  out  1  enable for A1/B1 registers.
- `ce_m`  out  1  enable for M register.
- `ce_p`  out  1  enable for P register.
- `rst_p`  out  1  one-cycle synchronous clear to P register.
- `opmode_acc`  out  1  0 = P loads product, 1 = P accumulates; meaningful when `ce_p`=1.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse, P holds job result.

## Operation
- States: IDLE, RUN, DRAIN, CLEAR, DONE.
- IDLE: `start_ready`=1. On `start_valid`: if `start_len`=0 go CLEAR, else latch length into remaining counter, go RUN. `start_valid` is ignored outside IDLE.
- RUN: `op_ready`=1. Operand accepted on `op_valid`&`op_ready`, and remaining counter decrements. The cycle the last operand is accepted, go DRAIN (`op_ready` drops next cycle).
- DRAIN: `op_ready`=0. Stay until no operand tag is in flight and the last `ce_p` has issued, then go DONE.
- CLEAR: `rst_p`=1 for this one cycle, then go DONE.
- DONE: `done`=1 for one cycle, then go IDLE.
- Per-operand tag shift chain carries valid and first-of-job flag. Enables come only from tags, never free-running.
- `ce_in` = accept (combinational from handshake, same cycle data is presented).
- `ce_mid` is asserted INREG cycles after accept. `ce_m` is asserted INREG+MIDREG cycles after accept. `ce_p` is asserted L = INREG+MIDREG+MREG+PREG-PREG... simplified: `ce_p` is asserted INREG+MIDREG+MREG cycles after accept.
- A bypassed stage's enable is still driven at its computed cycle and is harmless.
- `opmode_acc`=0 with the first operand's `ce_p`, and 1 for all later ones. No `rst_p` is issued for len≥1.
- Bubbles (`op_valid`=0 in RUN) generate no enables. Each stage holds its data until its own tag arrives, so gaps never corrupt or merge operands.

## Timing
- Reset (async assert): state IDLE, counter 0, tag chain empty. All of `op_ready`, `ce_*`, `rst_p`, `opmode_acc`, `busy`, `done` = 0. `start_ready`=1.
- Reset mid-job aborts immediately with no `done`. The P register is not cleared by this block; the next job's first `opmode_acc`=0 overwrites P.
- Let D = INREG+MIDREG+MREG. The last operand accepted at cycle t gives `ce_p` at t+D, and `done` at t+D+PREG+1 when PREG=1, or t+D+1 when PREG=0.
- len=0: start accepted at t gives `rst_p` at t+1 and `done` at t+2.
- Earliest next start is the cycle after `done`, i.e. IDLE.
- Max-length job (2^CNT_W-1): counter must not wrap.

## Test plan
- Default params, len=3, `op_valid` steady from cycle 0 -> `ce_in` at 0,1,2; `ce_mid` at 1,2,3; `ce_m` at 2,3,4; `ce_p` at 3,4,5 with `opmode_acc` 0,1,1; `done` at 7; `busy` high 0..7.
- Default params, len=2, `op_valid` at cycles 0 and 3 -> `ce_p` at 3 (acc=0) and 6 (acc=1); no enables at 1,2 for the input stage; `done` at 8.
- len=0 start at cycle 0 -> `rst_p` at 1, `done` at 2, no `ce_*` pulses, `op_ready` never high.
- All REG params 0, len=1, accept at 0 -> `ce_in`/`ce_mid`/`ce_m`/`ce_p` all at 0 with acc=0; `done` at 1.
- `rst` asserted mid-RUN of a len=5 job after 2 accepts -> outputs zero asynchronously, `done` never pulses, `start_ready`=1. A new len=1 job then completes normally with acc=0.
- `start_valid` held high during RUN/DRAIN/DONE -> ignored; a second job starts only in the IDLE cycle after `done`.
